fpmac_operand_feeder: RTL and testbench

Upstream feeder for the FP16 multiply-accumulate pipeline. It buffers a stream of half-precision words in a small FIFO and pairs consecutive words into multiplier operands (A, B). It issues a programmed number of pairs per accumulation block, clears the accumulator at block start, and waits out the MAC pipeline latency before signalling that the accumulated result is valid.

---
 rtl/fpmac_operand_feeder_if.sv | 44 ++++
 rtl/fpmac_operand_feeder.sv | 199 +++++++++++++++++++
 tb/tb_fpmac_operand_feeder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fpmac_operand_feeder_if.sv
// Bundle between the FP16 word source, the operand feeder and the MAC.
// Optional macro FPMAC_FEEDER_SPECIAL_EN adds the Inf/NaN flags op_special and special_seen.
interface fpmac_operand_feeder_if #(
    parameter int LEN_W = 8
);
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic [LEN_W-1:0] blk_len;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_valid;
    logic             op_last;
    logic             acc_clear;
    logic             busy;
    logic             done;
`ifdef FPMAC_FEEDER_SPECIAL_EN
    logic             op_special;
    logic             special_seen;

    modport master (
        output in_data, in_valid, start, blk_len,
        input  in_ready, op_a, op_b, op_valid, op_last, acc_clear, busy, done,
               op_special, special_seen
    );

    modport slave (
        input  in_data, in_valid, start, blk_len,
        output in_ready, op_a, op_b, op_valid, op_last, acc_clear, busy, done,
               op_special, special_seen
    );
`else
    modport master (
        output in_data, in_valid, start, blk_len,
        input  in_ready, op_a, op_b, op_valid, op_last, acc_clear, busy, done
    );

    modport slave (
        input  in_data, in_valid, start, blk_len,
        output in_ready, op_a, op_b, op_valid, op_last, acc_clear, busy, done
    );
`endif
endinterface

// File: rtl/fpmac_operand_feeder.sv
// FIFO-buffered FP16 operand pair feeder for the MAC pipeline, with block sequencing and drain wait.
// Optional macro FPMAC_FEEDER_SPECIAL_EN adds Inf/NaN operand detection.
module fpmac_operand_feeder #(
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 4,
    parameter int LEN_W    = 8
) (
    input  logic                  clk,
    input  logic                  Asynch_Reset,
    fpmac_operand_feeder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_TWO  = 2;
    localparam logic [DW-1:0] DRAIN_LOAD = PIPE_LAT[DW-1:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [15:0]   head0, head1;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pair_q, pair_d, pair_inc;
    logic [DW-1:0]    drain_q, drain_d;
    logic [15:0]      op_a_q, op_a_d, op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic             op_last_q, op_last_d;
    logic             acc_clear_q, acc_clear_d;

`ifdef FPMAC_FEEDER_SPECIAL_EN
    logic op_special_q, op_special_d;
    logic special_seen_q, special_seen_d;
    logic pair_special;

    assign pair_special = (head0[14:10] == 5'h1F) || (head1[14:10] == 5'h1F);
`endif

    // A full FIFO refuses pushes even when a pop frees space in the same cycle.
    assign push     = bus.in_valid && (count != CNT_FULL);
    assign head0    = mem[rd_ptr];
    assign head1    = mem[rd_ptr + AW'(1)];
    assign pair_inc = pair_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (Asynch_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(2);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - CNT_TWO;
                2'b11:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Asynch_Reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pair_q      <= '0;
            drain_q     <= '0;
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_valid_q  <= 1'b0;
            op_last_q   <= 1'b0;
            acc_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pair_q      <= pair_d;
            drain_q     <= drain_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_valid_q  <= op_valid_d;
            op_last_q   <= op_last_d;
            acc_clear_q <= acc_clear_d;
        end
    end

`ifdef FPMAC_FEEDER_SPECIAL_EN
    always_ff @(posedge clk) begin
        if (Asynch_Reset) begin
            op_special_q   <= 1'b0;
            special_seen_q <= 1'b0;
        end else begin
            op_special_q   <= op_special_d;
            special_seen_q <= special_seen_d;
        end
    end
`endif

    // Pairs are only taken whole, so an odd leftover word waits for the next block.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pair_d      = pair_q;
        drain_d     = drain_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_valid_d  = 1'b0;
        op_last_d   = 1'b0;
        acc_clear_d = 1'b0;
        pop         = 1'b0;
`ifdef FPMAC_FEEDER_SPECIAL_EN
        op_special_d   = 1'b0;
        special_seen_d = special_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d       = bus.blk_len;
                    pair_d      = '0;
                    acc_clear_d = 1'b1;
`ifdef FPMAC_FEEDER_SPECIAL_EN
                    special_seen_d = 1'b0;
`endif
                    if (bus.blk_len == '0) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (count >= CNT_TWO) begin
                    pop        = 1'b1;
                    op_a_d     = head0;
                    op_b_d     = head1;
                    op_valid_d = 1'b1;
                    pair_d     = pair_inc;
`ifdef FPMAC_FEEDER_SPECIAL_EN
                    op_special_d   = pair_special;
                    special_seen_d = special_seen_q | pair_special;
`endif
                    if (pair_inc == len_q) begin
                        op_last_d = 1'b1;
                        state_d   = DRAIN;
                        drain_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (count != CNT_FULL);
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.op_last   = op_last_q;
    assign bus.acc_clear = acc_clear_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
`ifdef FPMAC_FEEDER_SPECIAL_EN
    assign bus.op_special   = op_special_q;
    assign bus.special_seen = special_seen_q;
`endif

endmodule

// File: tb/tb_fpmac_operand_feeder.sv
// Directed self-checking bench for fpmac_operand_feeder (DEPTH=8, PIPE_LAT=4, LEN_W=8).
// Build with FPMAC_FEEDER_SPECIAL_EN defined to also exercise the Inf/NaN flags.
module tb_fpmac_operand_feeder;

    localparam int DEPTH    = 8;
    localparam int PIPE_LAT = 4;
    localparam int LEN_W    = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fpmac_operand_feeder_if #(.LEN_W(LEN_W)) bus ();

    fpmac_operand_feeder #(
        .DEPTH   (DEPTH),
        .PIPE_LAT(PIPE_LAT),
        .LEN_W   (LEN_W)
    ) dut (
        .clk         (clk),
        .Asynch_Reset(rst),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d,
                                 input logic st, input logic [LEN_W-1:0] len);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.start    = st;
        bus.blk_len  = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock with optional push; checks the issue strobe and, when expected, the pair.
    task automatic issueCycle(input string tag, input logic v, input logic [15:0] d,
                              input logic ev, input logic [15:0] ea,
                              input logic [15:0] eb, input logic el);
        applyStimulus(v, d, 1'b0, '0);
        tick();
        checkOutput({tag, ".op_valid"}, 32'(bus.op_valid), 32'(ev));
        checkOutput({tag, ".op_last"}, 32'(bus.op_last), 32'(el));
        if (ev) begin
            checkOutput({tag, ".op_a"}, 32'(bus.op_a), 32'(ea));
            checkOutput({tag, ".op_b"}, 32'(bus.op_b), 32'(eb));
        end
    endtask

    task automatic startBlock(input string tag, input logic [LEN_W-1:0] len,
                              input logic v, input logic [15:0] d);
        applyStimulus(v, d, 1'b1, len);
        tick();
        checkOutput({tag, ".acc_clear"}, 32'(bus.acc_clear), 32'd1);
        checkOutput({tag, ".op_valid"}, 32'(bus.op_valid), 32'd0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Leaves the bench in the cycle where done is expected high.
    task automatic waitDone(input string tag);
        for (int k = 1; k <= PIPE_LAT + 1; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, '0);
            tick();
            checkOutput({tag, ".done"}, 32'(bus.done), (k == PIPE_LAT + 1) ? 32'd1 : 32'd0);
            checkOutput({tag, ".drain_op_valid"}, 32'(bus.op_valid), 32'd0);
        end
    endtask

    task automatic idleCheck(input string tag);
        applyStimulus(1'b0, 16'h0000, 1'b0, '0);
        tick();
        checkOutput({tag, ".done_low"}, 32'(bus.done), 32'd0);
        checkOutput({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, '0);
        tick();
        tick();
        checkOutput("reset.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset.op_valid", 32'(bus.op_valid), 32'd0);
        checkOutput("reset.busy", 32'(bus.busy), 32'd0);
        checkOutput("reset.done", 32'(bus.done), 32'd0);
        checkOutput("reset.acc_clear", 32'(bus.acc_clear), 32'd0);
        checkOutput("reset.op_a", 32'(bus.op_a), 32'h0);
        checkOutput("reset.op_b", 32'(bus.op_b), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] basic two-pair block");
        issueCycle("b1.push0", 1'b1, 16'h3C00, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("b1.push1", 1'b1, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("b1.push2", 1'b1, 16'h4200, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("b1.push3", 1'b1, 16'h4400, 1'b0, 16'h0, 16'h0, 1'b0);
        startBlock("b1.start", 8'd2, 1'b0, 16'h0);
        issueCycle("b1.pair0", 1'b0, 16'h0, 1'b1, 16'h3C00, 16'h4000, 1'b0);
        issueCycle("b1.pair1", 1'b0, 16'h0, 1'b1, 16'h4200, 16'h4400, 1'b1);
        waitDone("b1");
        idleCheck("b1");

        $display("[TB] full FIFO backpressure");
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("full.ready_before_push", 32'(bus.in_ready), 32'd1);
            issueCycle("full.push", 1'b1, 16'h1000 + 16'(i), 1'b0, 16'h0, 16'h0, 1'b0);
        end
        checkOutput("full.ready_after_8", 32'(bus.in_ready), 32'd0);
        issueCycle("full.hold9", 1'b1, 16'h1008, 1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("full.ready_held", 32'(bus.in_ready), 32'd0);
        startBlock("full.start", 8'd4, 1'b1, 16'h1008);
        checkOutput("full.ready_at_start", 32'(bus.in_ready), 32'd0);
        issueCycle("full.pair0", 1'b1, 16'h1008, 1'b1, 16'h1000, 16'h1001, 1'b0);
        checkOutput("full.ready_after_pop", 32'(bus.in_ready), 32'd1);
        issueCycle("full.pair1", 1'b1, 16'h1008, 1'b1, 16'h1002, 16'h1003, 1'b0);
        issueCycle("full.pair2", 1'b0, 16'h0, 1'b1, 16'h1004, 16'h1005, 1'b0);
        issueCycle("full.pair3", 1'b0, 16'h0, 1'b1, 16'h1006, 16'h1007, 1'b1);
        waitDone("full");
        idleCheck("full");

        $display("[TB] zero-length block");
        startBlock("zero.start", 8'd0, 1'b0, 16'h0);
        waitDone("zero");
        idleCheck("zero");

        $display("[TB] odd word count across blocks");
        startBlock("odd.start", 8'd3, 1'b0, 16'h0);
        issueCycle("odd.c0", 1'b1, 16'h2000, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("odd.c1", 1'b0, 16'h0, 1'b1, 16'h1008, 16'h2000, 1'b0);
        issueCycle("odd.c2", 1'b1, 16'h2001, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("odd.c3", 1'b1, 16'h2002, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("odd.c4", 1'b1, 16'h2003, 1'b1, 16'h2001, 16'h2002, 1'b0);
        issueCycle("odd.c5", 1'b1, 16'h2004, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("odd.c6", 1'b1, 16'h2005, 1'b1, 16'h2003, 16'h2004, 1'b1);
        waitDone("odd");
        idleCheck("odd");
        startBlock("odd2.start", 8'd1, 1'b1, 16'h2006);
        issueCycle("odd2.pair", 1'b0, 16'h0, 1'b1, 16'h2005, 16'h2006, 1'b1);
        waitDone("odd2");
        idleCheck("odd2");

        $display("[TB] reset in the middle of a block");
        issueCycle("rst.push0", 1'b1, 16'h3000, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("rst.push1", 1'b1, 16'h3001, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("rst.push2", 1'b1, 16'h3002, 1'b0, 16'h0, 16'h0, 1'b0);
        startBlock("rst.start", 8'd4, 1'b0, 16'h0);
        issueCycle("rst.pair0", 1'b0, 16'h0, 1'b1, 16'h3000, 16'h3001, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, '0);
        tick();
        checkOutput("rst.op_valid", 32'(bus.op_valid), 32'd0);
        checkOutput("rst.op_a", 32'(bus.op_a), 32'h0);
        checkOutput("rst.op_b", 32'(bus.op_b), 32'h0);
        checkOutput("rst.busy", 32'(bus.busy), 32'd0);
        checkOutput("rst.in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst.done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("rst.no_done", 32'(bus.done), 32'd0);
            checkOutput("rst.stay_idle", 32'(bus.busy), 32'd0);
        end
        issueCycle("rst.repush0", 1'b1, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("rst.repush1", 1'b1, 16'h4001, 1'b0, 16'h0, 16'h0, 1'b0);
        startBlock("rst.restart", 8'd1, 1'b0, 16'h0);
        issueCycle("rst.flushed_pair", 1'b0, 16'h0, 1'b1, 16'h4000, 16'h4001, 1'b1);
        waitDone("rst2");
        idleCheck("rst2");

`ifdef FPMAC_FEEDER_SPECIAL_EN
        $display("[TB] Inf/NaN detection");
        issueCycle("sp.push0", 1'b1, 16'h7C00, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("sp.push1", 1'b1, 16'h3C00, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("sp.push2", 1'b1, 16'h3C00, 1'b0, 16'h0, 16'h0, 1'b0);
        issueCycle("sp.push3", 1'b1, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b0);
        startBlock("sp.start", 8'd2, 1'b0, 16'h0);
        checkOutput("sp.seen_cleared", 32'(bus.special_seen), 32'd0);
        issueCycle("sp.pair0", 1'b0, 16'h0, 1'b1, 16'h7C00, 16'h3C00, 1'b0);
        checkOutput("sp.op_special0", 32'(bus.op_special), 32'd1);
        issueCycle("sp.pair1", 1'b0, 16'h0, 1'b1, 16'h3C00, 16'h4000, 1'b1);
        checkOutput("sp.op_special1", 32'(bus.op_special), 32'd0);
        waitDone("sp");
        checkOutput("sp.seen_at_done", 32'(bus.special_seen), 32'd1);
        idleCheck("sp");
        startBlock("sp2.start", 8'd0, 1'b0, 16'h0);
        checkOutput("sp2.seen_cleared", 32'(bus.special_seen), 32'd0);
        waitDone("sp2");
        idleCheck("sp2");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
